// File: rtl/cluster_chunk_sequencer.sv
// Control sequencer for one Compute_Cluster across a multi-chunk pass.
// It gates the IFM and filter beat streams into the write bank of the
// double-buffered chunk memories and launches compute on the read bank.
// It waits for chunk_end and overlaps the next load with the current compute.
// Handshake: a beat transfers in any cycle where valid and ready are both high
// at the rising clock edge. Valid may rise or fall freely, and ready never
// depends combinationally on valid.
// Only control passes through this block; the data buses bypass it.
module cluster_chunk_sequencer #(
  parameter int MEM_SIZE         = 128,
  parameter int BUS_SIZE         = 8,
  parameter int OUTPUT_BUF_NUM   = 32,
  parameter int COMPUTE_UNIT_NUM = 32,
  parameter int CHUNK_NUM_MAX    = 256,
  localparam int BEATS = MEM_SIZE / BUS_SIZE,
  localparam int CW    = $clog2(CHUNK_NUM_MAX) + 1,
  localparam int BW    = $clog2(BEATS),
  localparam int AW    = $clog2(OUTPUT_BUF_NUM),
  localparam int UW    = $clog2(COMPUTE_UNIT_NUM)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [CW-1:0] num_chunk_i,
  input  logic [AW-1:0] acc_buf_sel_i,
  output logic          busy_o,
  output logic          done_o,
  input  logic          ifm_valid_i,
  output logic          ifm_ready_o,
  input  logic          filter_valid_i,
  output logic          filter_ready_o,
  output logic          ifm_wr_valid_o,
  output logic [BW-1:0] ifm_wr_count_o,
  output logic          ifm_wr_sel_o,
  output logic          ifm_rd_sel_o,
  output logic          filter_wr_valid_o,
  output logic [BW-1:0] filter_wr_count_o,
  output logic          filter_wr_sel_o,
  output logic          filter_rd_sel_o,
  output logic [UW-1:0] filter_wr_order_sel_o,
  output logic          init_o,
  output logic          chunk_start_o,
  input  logic          chunk_end_i,
  output logic [AW-1:0] acc_buf_sel_o,
  output logic [2:0]    dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    LOAD0 = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic          wr_bank_q, rd_bank_q;
  logic [BW-1:0] ifm_cnt_q, filt_cnt_q;
  logic [UW-1:0] filt_unit_q;
  logic          ifm_done_q, filt_done_q;
  logic [CW-1:0] issued_q, num_chunk_q;
  logic [AW-1:0] acc_q;
  logic          end_q, end_seen_q, chunk_start_q;

  logic more, loading, ifm_acc, filt_acc, ifm_last, filt_last;
  logic load_fin, issue_go, start_ok;

  // Loader gating, load completion and the issue decision for the next cycle.
  always_comb begin
    start_ok  = (state_q == IDLE) && start_i && (num_chunk_i != '0);
    more      = (issued_q < num_chunk_q);
    loading   = (state_q == LOAD0) || ((state_q == RUN) && more);
    ifm_ready_o    = loading && !ifm_done_q;
    filter_ready_o = loading && !filt_done_q;
    ifm_acc   = ifm_valid_i && ifm_ready_o;
    filt_acc  = filter_valid_i && filter_ready_o;
    ifm_last  = ifm_acc && (ifm_cnt_q == BW'(BEATS - 1));
    filt_last = filt_acc && (filt_cnt_q == BW'(BEATS - 1)) &&
                (filt_unit_q == UW'(COMPUTE_UNIT_NUM - 1));
    // Finishing this cycle counts as done so the launch lands on the next cycle.
    load_fin  = (ifm_done_q || ifm_last) && (filt_done_q || filt_last);
    issue_go  = ((state_q == LOAD0) && load_fin) ||
                ((state_q == RUN) && more && load_fin && (end_q || end_seen_q));
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = INIT;
      INIT:    state_d = LOAD0;
      LOAD0:   if (load_fin) state_d = RUN;
      RUN:     if (!more) state_d = DRAIN;
      DRAIN:   if (end_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the state.
  always_comb begin
    init_o      = (state_q == INIT);
    done_o      = (state_q == DONE);
    busy_o      = (state_q == INIT) || (state_q == LOAD0) ||
                  (state_q == RUN)  || (state_q == DRAIN);
    dbg_state_o = state_q;
  end

  // Beat counters, bank swap, chunk bookkeeping and captured pass settings.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      ifm_cnt_q     <= '0;
      filt_cnt_q    <= '0;
      filt_unit_q   <= '0;
      ifm_done_q    <= 1'b0;
      filt_done_q   <= 1'b0;
      issued_q      <= '0;
      num_chunk_q   <= '0;
      acc_q         <= '0;
      end_q         <= 1'b0;
      end_seen_q    <= 1'b0;
      chunk_start_q <= 1'b0;
    end else begin
      // chunk_end may still be high from the previous chunk during the launch cycle.
      end_q         <= chunk_end_i && !chunk_start_q;
      chunk_start_q <= issue_go;
      if (start_ok) begin
        // Every pass begins on bank 0 so the bank pattern is pass-independent.
        num_chunk_q <= num_chunk_i;
        acc_q       <= acc_buf_sel_i;
        wr_bank_q   <= 1'b0;
        rd_bank_q   <= 1'b0;
        issued_q    <= '0;
        ifm_cnt_q   <= '0;
        filt_cnt_q  <= '0;
        filt_unit_q <= '0;
        ifm_done_q  <= 1'b0;
        filt_done_q <= 1'b0;
        end_seen_q  <= 1'b0;
      end else if (issue_go) begin
        rd_bank_q   <= wr_bank_q;
        wr_bank_q   <= ~wr_bank_q;
        issued_q    <= issued_q + CW'(1);
        ifm_cnt_q   <= '0;
        filt_cnt_q  <= '0;
        filt_unit_q <= '0;
        ifm_done_q  <= 1'b0;
        filt_done_q <= 1'b0;
        end_seen_q  <= 1'b0;
      end else begin
        if (ifm_acc) begin
          ifm_cnt_q <= ifm_cnt_q + BW'(1);
          if (ifm_last) ifm_done_q <= 1'b1;
        end
        if (filt_acc) begin
          filt_cnt_q <= filt_cnt_q + BW'(1);
          if (filt_cnt_q == BW'(BEATS - 1)) filt_unit_q <= filt_unit_q + UW'(1);
          if (filt_last) filt_done_q <= 1'b1;
        end
        // Remember an early chunk_end while the next load is still running.
        if ((state_q == RUN) && more && end_q) end_seen_q <= 1'b1;
      end
    end
  end

  assign ifm_wr_valid_o        = ifm_acc;
  assign filter_wr_valid_o     = filt_acc;
  assign ifm_wr_count_o        = ifm_cnt_q;
  assign filter_wr_count_o     = filt_cnt_q;
  assign filter_wr_order_sel_o = filt_unit_q;
  assign ifm_wr_sel_o          = wr_bank_q;
  assign ifm_rd_sel_o          = rd_bank_q;
  assign filter_wr_sel_o       = wr_bank_q;
  assign filter_rd_sel_o       = rd_bank_q;
  assign chunk_start_o         = chunk_start_q;
  assign acc_buf_sel_o         = acc_q;

endmodule

// File: tb/tb_cluster_chunk_sequencer.sv
// Bench for cluster_chunk_sequencer: directed passes, expected events queued
// at stimulus time and popped by an independent monitor at the falling edge.
module tb_cluster_chunk_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [8:0] num_chunk = '0;
  logic [4:0] acc_in = '0;
  logic       busy, done;
  logic       ifm_valid = 1'b0, ifm_ready;
  logic       filter_valid = 1'b0, filter_ready;
  logic       ifm_wr_valid, ifm_wr_sel, ifm_rd_sel;
  logic [3:0] ifm_wr_count;
  logic       filter_wr_valid, filter_wr_sel, filter_rd_sel;
  logic [3:0] filter_wr_count;
  logic [4:0] filter_wr_order_sel;
  logic       init, chunk_start;
  logic       chunk_end = 1'b0;
  logic [4:0] acc_out;
  logic [2:0] dbg_state;

  cluster_chunk_sequencer dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .num_chunk_i(num_chunk),
    .acc_buf_sel_i(acc_in), .busy_o(busy), .done_o(done),
    .ifm_valid_i(ifm_valid), .ifm_ready_o(ifm_ready),
    .filter_valid_i(filter_valid), .filter_ready_o(filter_ready),
    .ifm_wr_valid_o(ifm_wr_valid), .ifm_wr_count_o(ifm_wr_count),
    .ifm_wr_sel_o(ifm_wr_sel), .ifm_rd_sel_o(ifm_rd_sel),
    .filter_wr_valid_o(filter_wr_valid), .filter_wr_count_o(filter_wr_count),
    .filter_wr_sel_o(filter_wr_sel), .filter_rd_sel_o(filter_rd_sel),
    .filter_wr_order_sel_o(filter_wr_order_sel), .init_o(init),
    .chunk_start_o(chunk_start), .chunk_end_i(chunk_end),
    .acc_buf_sel_o(acc_out), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [4:0]  ifm_q[$];    // {wr_sel, count}
  logic [9:0]  filt_q[$];   // {wr_sel, order_sel, count}
  logic [33:0] start_q[$];  // {cycle (0 = any), rd_sel, wr_sel}
  logic [31:0] init_q[$];   // cycle
  logic [31:0] done_q[$];   // cycle (0 = any)
  int n_checks = 0;
  int n_pass = 0;
  int done_seen = 0;
  int compute_len = 1;
  int end_cnt = 0;
  bit gap_en = 1'b0;
  bit valid_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic note_fail(input string name);
    n_checks++;
    $display("FAIL %s actual=unexpected-event expected=none (cycle %0d)", name, cyc);
  endtask

  function automatic logic [63:0] all_outputs();
    return 64'({busy, done, ifm_ready, filter_ready, ifm_wr_valid, ifm_wr_count,
                ifm_wr_sel, ifm_rd_sel, filter_wr_valid, filter_wr_count,
                filter_wr_sel, filter_rd_sel, filter_wr_order_sel, init,
                chunk_start, acc_out, dbg_state});
  endfunction

  // ---------------- input drivers (valids, compute model) ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      ifm_valid    = gap_en ? ($urandom_range(0, 1) == 1) : valid_en;
      filter_valid = gap_en ? ($urandom_range(0, 1) == 1) : valid_en;
      chunk_end    = (end_cnt == 1);
      if (end_cnt != 0) end_cnt--;
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [4:0]  ie;
    logic [9:0]  fe;
    logic [33:0] se;
    logic [31:0] ce;
    forever begin
      @(negedge clk);
      if (ifm_wr_valid) begin
        if (ifm_q.size() == 0) note_fail("ifm_beat_extra");
        else begin
          ie = ifm_q.pop_front();
          check("ifm_beat", 64'({ifm_wr_sel, ifm_wr_count}), 64'(ie));
        end
      end
      if (filter_wr_valid) begin
        if (filt_q.size() == 0) note_fail("filter_beat_extra");
        else begin
          fe = filt_q.pop_front();
          check("filter_beat", 64'({filter_wr_sel, filter_wr_order_sel, filter_wr_count}), 64'(fe));
        end
      end
      if (init) begin
        if (init_q.size() == 0) note_fail("init_extra");
        else begin
          ce = init_q.pop_front();
          check("init_cycle", 64'(cyc), 64'(ce));
        end
      end
      if (chunk_start) begin
        end_cnt = compute_len;
        if (start_q.size() == 0) note_fail("chunk_start_extra");
        else begin
          se = start_q.pop_front();
          if (se[33:2] != 0) check("chunk_start_cycle", 64'(cyc), 64'(se[33:2]));
          check("chunk_start_sels", 64'({ifm_rd_sel, ifm_wr_sel, filter_rd_sel, filter_wr_sel}),
                64'({se[1], se[0], se[1], se[0]}));
        end
      end
      if (done) begin
        done_seen++;
        check("busy_low_at_done", 64'(busy), 64'(0));
        if (done_q.size() == 0) note_fail("done_extra");
        else begin
          ce = done_q.pop_front();
          if (ce != 0) check("done_cycle", 64'(cyc), 64'(ce));
        end
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  // Issues a start and queues every expected event of the pass. Timed
  // expectations assume both valids held high: load of chunk k+1 spans 512
  // cycles from the previous launch, and an end at launch+len is seen one
  // cycle later, so the next launch is at max(launch+512, launch+len+2).
  task automatic run_pass(input int n, input int acc, input int len, input bit timed);
    int s;
    int iss;
    @(posedge clk);
    #1;
    s = cyc;
    start = 1'b1;
    num_chunk = 9'(n);
    acc_in = 5'(acc);
    compute_len = len;
    init_q.push_back(32'(s + 1));
    iss = s + 514;
    for (int k = 0; k < n; k++) begin
      for (int b = 0; b < 16; b++) ifm_q.push_back({1'(k % 2), 4'(b)});
      for (int u = 0; u < 32; u++)
        for (int b = 0; b < 16; b++) filt_q.push_back({1'(k % 2), 5'(u), 4'(b)});
      start_q.push_back({timed ? 32'(iss) : 32'd0, 1'(k % 2), 1'((k + 1) % 2)});
      if (k < n - 1) iss = (len + 2 > 512) ? iss + len + 2 : iss + 512;
    end
    done_q.push_back(timed ? 32'(iss + len + 2) : 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int want, input int budget);
    for (int i = 0; i < budget && done_seen < want; i++) @(posedge clk);
    if (done_seen < want) note_fail("pass_timeout");
    repeat (3) @(posedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int want;
    #2;
    check("reset_outputs", all_outputs(), 64'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    valid_en = 1'b1;

    // One chunk, plus a start attempt while busy that must be ignored.
    want = done_seen + 1;
    run_pass(1, 5, 86, 1'b1);
    @(negedge clk);
    check("acc_capture", 64'(acc_out), 64'(5));
    check("busy_after_start", 64'(busy), 64'(1));
    repeat (8) @(posedge clk);
    #1;
    start = 1'b1; num_chunk = 9'd5; acc_in = 5'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("acc_hold_while_busy", 64'(acc_out), 64'(5));
    wait_done(want, 2000);

    // Three chunks, compute shorter than the next load.
    want = done_seen + 1;
    run_pass(3, 1, 100, 1'b1);
    wait_done(want, 3000);

    // chunk_end arrives while the filter load is at beat 300.
    want = done_seen + 1;
    run_pass(2, 2, 300, 1'b1);
    wait_done(want, 3000);

    // Compute longer than the load: load_done already set when chunk_end comes.
    want = done_seen + 1;
    run_pass(2, 3, 700, 1'b1);
    wait_done(want, 4000);

    // chunk_end seen in the very cycle the load finishes.
    want = done_seen + 1;
    run_pass(2, 4, 510, 1'b1);
    wait_done(want, 3000);

    // Random valid gaps: beat sequences must stay gap-free and complete.
    gap_en = 1'b1;
    want = done_seen + 1;
    run_pass(2, 6, 40, 1'b0);
    wait_done(want, 8000);
    gap_en = 1'b0;

    // num_chunk = 0 is ignored.
    @(posedge clk);
    #1;
    start = 1'b1; num_chunk = 9'd0; acc_in = 5'd17;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("busy_zero_chunks", 64'(busy), 64'(0));
    end
    check("acc_zero_chunks", 64'(acc_out), 64'(6));

    // Reset in the middle of RUN on chunk 1, then a clean one-chunk pass.
    run_pass(3, 7, 100, 1'b1);
    repeat (698) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrun_reset_outputs", all_outputs(), 64'(0));
    ifm_q.delete(); filt_q.delete(); start_q.delete(); init_q.delete(); done_q.delete();
    end_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    want = done_seen + 1;
    run_pass(1, 8, 86, 1'b1);
    wait_done(want, 2000);

    check("ifm_q_drained", 64'(ifm_q.size()), 64'(0));
    check("filter_q_drained", 64'(filt_q.size()), 64'(0));
    check("start_q_drained", 64'(start_q.size()), 64'(0));
    check("init_q_drained", 64'(init_q.size()), 64'(0));
    check("done_q_drained", 64'(done_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cluster_chunk_sequencer.md
Name: cluster_chunk_sequencer

Overview:
- Sequences one Compute_Cluster through a multi-chunk convolution pass.
- Gates the upstream IFM and filter beat streams into the cluster's double-buffered chunk memories. Generates the write counts, bank selects and filter order select.
- Issues init and chunk_start, and waits for chunk_end. The load of chunk k+1 overlaps the compute of chunk k.
- Sits between the DMA/stream front end and the cluster. Data buses bypass the block; only control passes through it.

Parameters:
- MEM_SIZE, 128, chunk memory bytes per unit.
- BUS_SIZE, 8, bytes per write beat; BEATS = MEM_SIZE/BUS_SIZE (16).
- OUTPUT_BUF_NUM, 32, accumulator buffers per unit.
- COMPUTE_UNIT_NUM, 32, units in the cluster.
- CHUNK_NUM_MAX, 256, maximum chunks per pass; CW = $clog2(CHUNK_NUM_MAX)+1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- start_i  in  1  pass request, accepted only in IDLE.
- num_chunk_i  in  CW  chunks in the pass; captured at start.
- acc_buf_sel_i  in  $clog2(OUTPUT_BUF_NUM)  accumulator buffer; captured at start.
- busy_o  out  1  high from accepted start until done_o.
- done_o  out  1  one-cycle pulse at end of pass.
- ifm_valid_i / ifm_ready_o  in/out  1  IFM beat handshake.
- filter_valid_i / filter_ready_o  in/out  1  filter beat handshake.
- ifm_wr_valid_o  out  1  ifm_valid_i & ifm_ready_o.
- ifm_wr_count_o  out  $clog2(BEATS)  IFM beat index.
- ifm_wr_sel_o, ifm_rd_sel_o  out  1  IFM write bank / compute bank.
- filter_wr_valid_o  out  1  filter_valid_i & filter_ready_o.
- filter_wr_count_o  out  $clog2(BEATS)  filter beat index within a unit.
- filter_wr_sel_o, filter_rd_sel_o  out  1  filter write bank / compute bank (equal to the IFM selects).
- filter_wr_order_sel_o  out  $clog2(COMPUTE_UNIT_NUM)  target unit of the filter beat.
- init_o  out  1  one-cycle accumulator clear pulse.
- chunk_start_o  out  1  one-cycle compute launch pulse.
- chunk_end_i  in  1  AND of unit chunk_end; level.
- acc_buf_sel_o  out  $clog2(OUTPUT_BUF_NUM)  registered captured acc_buf_sel_i.

Behaviour:
- Reset: all outputs 0; state IDLE; wr_bank=0, rd_bank=0; all counters 0.
- FSM states: IDLE, INIT, LOAD0, RUN, DRAIN, DONE.
- IDLE: start_i with num_chunk_i≠0 → INIT, capturing num_chunk and acc_buf_sel. start_i with num_chunk_i=0 is ignored. start_i outside IDLE is ignored.
- INIT: init_o=1 for one cycle → LOAD0.
- Loader (active in LOAD0, and in RUN when a next chunk exists):
  - IFM: ifm_ready_o=1 until BEATS beats are accepted; ifm_wr_count_o counts 0..BEATS-1.
  - Filter: filter_ready_o=1 until COMPUTE_UNIT_NUM*BEATS beats are accepted. filter_wr_count_o counts 0..BEATS-1; filter_wr_order_sel_o increments on each count wrap (unit 0 first).
  - The IFM and filter counters run independently and concurrently. Each counter advances only on an accepted beat.
  - load_done is set when both finish; ready stays 0 after finish.
- Chunk launch (issue) cycle, the cycle after load_done is set:
  - chunk_start_o=1.
  - rd_bank ← wr_bank, wr_bank ← ~wr_bank, registered so the new selects are visible in the pulse cycle.
  - Loader counters and load_done clear.
  - chunks_issued increments.
- LOAD0 → RUN at the first issue cycle. In RUN the loader fills wr_bank only if chunks_issued < num_chunk.
- chunk_end_i is ignored in the issue cycle and sampled from the following cycle.
- RUN, chunk_end_i=1 and more chunks remain:
  - If load_done=1: issue next cycle.
  - Otherwise: hold until load_done; the early chunk_end is latched.
- RUN, chunk_end_i=1 and load_done=1 in the same cycle: issue next cycle.
- RUN, last chunk issued: → DRAIN; loader idle, ready=0.
- DRAIN, chunk_end_i=1 → DONE.
- DONE: done_o=1 for one cycle, busy_o=0 in that cycle → IDLE.
- busy_o=1 in INIT, LOAD0, RUN and DRAIN.
- Reset mid-pass: immediate return to reset values; partially loaded banks are abandoned; no done_o.
- Stalls: deasserted valid freezes the corresponding counter. No beat is dropped or duplicated.

Test Plan:
- num_chunk=1, valids held high: start at cycle 0 → init_o at cycle 1; 16 IFM and 512 filter beats; chunk_start_o at cycle 514 with rd_sel=0, wr_sel=1; chunk_end_i at 600 → done_o at 602.
- num_chunk=3, valids high, compute 100 cycles: loads of chunks 1 and 2 overlap compute; bank selects alternate 0,1,0; exactly 3 chunk_start_o pulses, one done_o.
- Random valid gaps (50%): ifm_wr_count_o and filter_wr_count_o/order_sel sequences are gap-free 0..15 and 0..31. Total accepted beats equal 16 and 512 per chunk.
- chunk_end_i asserted while the filter load is at beat 300: no chunk_start_o until beat 511 is accepted; pulse follows on the next cycle.
- start_i with num_chunk_i=0 → no busy_o; start_i while busy → ignored and captured values unchanged.
- rst_i pulsed mid-RUN on chunk 1 → all outputs 0 the same cycle; a new start restarts from bank 0 and behaves as in scenario 1.
